// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the evaluator's arithmetic responders
// (state encoding, canonical constants, unpacked operand view).
package fp_pkg;

    localparam int FP_EXP_LEN      = 8;
    localparam int FP_MANTISSA_LEN = 23;

    localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;
    localparam logic [31:0] FP_POS_INF   = 32'h7F800000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_MULT,
        ST_NORM,
        ST_ROUND
    } fp_mult_state_t;

    typedef struct packed {
        logic                       sign;
        logic [FP_EXP_LEN-1:0]      exp;
        logic [FP_MANTISSA_LEN:0]   significand;
        logic                       is_zero;
        logic                       is_inf;
        logic                       is_nan;
    } fp_unpacked_t;

    function automatic int fp_bias(input int exp_len);
        return (1 << (exp_len - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_mult_responder_if.sv
// Request/response bundle between a requester and the FP multiply responder.
interface fp_mult_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mult_start;
    logic [DATA_WIDTH-1:0] mult_operand_a;
    logic [DATA_WIDTH-1:0] mult_operand_b;
    logic [DATA_WIDTH-1:0] mult_result;
    logic                  mult_result_ready;
    logic                  mult_busy;

    modport master (
        output mult_start, mult_operand_a, mult_operand_b,
        input  mult_result, mult_result_ready, mult_busy
    );

    modport slave (
        input  mult_start, mult_operand_a, mult_operand_b,
        output mult_result, mult_result_ready, mult_busy
    );
endinterface

// File: rtl/fp_classify.sv
// Combinational single-precision unpack with special-value flags.
// Subnormals are flushed: a zero exponent field reads as zero.
module fp_classify
    import fp_pkg::*;
(
    input  logic [1+FP_EXP_LEN+FP_MANTISSA_LEN-1:0] operand,
    output fp_unpacked_t                            unpacked
);
    logic [FP_EXP_LEN-1:0]      exp_field;
    logic [FP_MANTISSA_LEN-1:0] frac;
    logic                       exp_zero;
    logic                       exp_ones;

    assign exp_field = operand[FP_EXP_LEN+FP_MANTISSA_LEN-1 -: FP_EXP_LEN];
    assign frac      = operand[FP_MANTISSA_LEN-1:0];
    assign exp_zero  = (exp_field == '0);
    assign exp_ones  = (exp_field == '1);

    always_comb begin
        unpacked.sign        = operand[FP_EXP_LEN+FP_MANTISSA_LEN];
        unpacked.exp         = exp_field;
        unpacked.is_zero     = exp_zero;
        unpacked.is_inf      = exp_ones && (frac == '0);
        unpacked.is_nan      = exp_ones && (frac != '0);
        unpacked.significand = exp_zero ? '0 : {1'b1, frac};
    end
endmodule

// File: rtl/fp_mult_responder.sv
// Sequential shift-add IEEE-754 single-precision multiplier behind a
// start/ready handshake; round-to-nearest-even, flush-to-zero on underflow.
module fp_mult_responder
    import fp_pkg::*;
#(
    parameter int EXP_LEN      = FP_EXP_LEN,
    parameter int MANTISSA_LEN = FP_MANTISSA_LEN,
    parameter int DATA_WIDTH   = 1 + EXP_LEN + MANTISSA_LEN
) (
    input  logic                 clock,
    input  logic                 reset,
    fp_mult_responder_if.slave   bus
);
    localparam int SIG_W = MANTISSA_LEN + 1;
    localparam int CNT_W = $clog2(SIG_W);
    localparam int EXP_W = EXP_LEN + 2;
    localparam logic signed [EXP_W-1:0] BIAS_S    = EXP_W'(fp_bias(EXP_LEN));
    localparam logic signed [EXP_W-1:0] EXP_MAX_S = EXP_W'((1 << EXP_LEN) - 1);

    fp_mult_state_t state, state_next;

    logic [DATA_WIDTH-1:0]   op_a, op_b, result;
    logic                    ready, busy;
    fp_unpacked_t            ua, ub;
    logic [CNT_W-1:0]        count;
    logic [2*SIG_W-1:0]      acc;
    logic signed [EXP_W-1:0] exp_sum, exp_rnd;
    logic                    sign, guard, sticky, round_up, carry, special, sign_ab;
    logic [MANTISSA_LEN-1:0] mant, mant_rnd;
    logic [DATA_WIDTH-1:0]   special_val, rounded;

    fp_classify u_class_a (.operand(op_a), .unpacked(ua));
    fp_classify u_class_b (.operand(op_b), .unpacked(ub));

    assign bus.mult_result       = result;
    assign bus.mult_result_ready = ready;
    assign bus.mult_busy         = busy;

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (bus.mult_start) state_next = ST_UNPACK;
            ST_UNPACK: state_next = special ? ST_IDLE : ST_MULT;
            ST_MULT:   if (count == CNT_W'(MANTISSA_LEN)) state_next = ST_NORM;
            ST_NORM:   state_next = ST_ROUND;
            ST_ROUND:  state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // NaN outranks Inf, and Inf x 0 is invalid, so the checks are ordered.
    always_comb begin
        sign_ab = ua.sign ^ ub.sign;
        special = ua.is_nan | ub.is_nan | ua.is_inf | ub.is_inf | ua.is_zero | ub.is_zero;
        if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_zero) || (ub.is_inf && ua.is_zero))
            special_val = DATA_WIDTH'(FP_CANON_NAN);
        else if (ua.is_inf || ub.is_inf)
            special_val = DATA_WIDTH'(FP_POS_INF) | {sign_ab, {(DATA_WIDTH-1){1'b0}}};
        else
            special_val = {sign_ab, {(DATA_WIDTH-1){1'b0}}};
    end

    always_comb begin
        round_up          = guard & (sticky | mant[0]);
        {carry, mant_rnd} = {1'b0, mant} + {{MANTISSA_LEN{1'b0}}, round_up};
        exp_rnd           = exp_sum + $signed({{(EXP_W-1){1'b0}}, carry});
        if (exp_rnd >= EXP_MAX_S)
            rounded = {sign, {EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b0}}};
        else if (exp_rnd <= 0)
            rounded = {sign, {(DATA_WIDTH-1){1'b0}}};
        else
            rounded = {sign, exp_rnd[EXP_LEN-1:0], mant_rnd};
    end

    always_ff @(posedge clock) begin
        ready <= 1'b0;
        if (reset) begin
            result <= '0;
            busy   <= 1'b0;
            count  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.mult_start) begin
                    op_a <= bus.mult_operand_a;
                    op_b <= bus.mult_operand_b;
                    busy <= 1'b1;
                end
                ST_UNPACK: begin
                    sign    <= sign_ab;
                    count   <= '0;
                    acc     <= '0;
                    exp_sum <= $signed({2'b00, ua.exp}) + $signed({2'b00, ub.exp}) - BIAS_S;
                    if (special) begin
                        result <= special_val;
                        ready  <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                ST_MULT: begin
                    if (ub.significand[count])
                        acc <= acc + ({{SIG_W{1'b0}}, ua.significand} << count);
                    count <= count + 1'b1;
                end
                ST_NORM: begin
                    if (acc[2*SIG_W-1]) begin
                        mant    <= acc[2*SIG_W-2 -: MANTISSA_LEN];
                        guard   <= acc[SIG_W-1];
                        sticky  <= |acc[SIG_W-2:0];
                        exp_sum <= exp_sum + EXP_W'(1);
                    end else begin
                        mant    <= acc[2*SIG_W-3 -: MANTISSA_LEN];
                        guard   <= acc[SIG_W-2];
                        sticky  <= |acc[SIG_W-3:0];
                    end
                end
                ST_ROUND: begin
                    result <= rounded;
                    ready  <= 1'b1;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
